// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M multiply/divide unit (radix-2 shift-add and
//            restoring shift-subtract); optional MULDIV_FAST_MUL_EN macro
//            replaces the iterative multiply with a single-cycle multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [4:0]      ALU_Ctrl,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [4:0] c_OP_MUL    = 5'b01011;
   localparam logic [4:0] c_OP_MULH   = 5'b01100;
   localparam logic [4:0] c_OP_MULHSU = 5'b01101;
   localparam logic [4:0] c_OP_MULHU  = 5'b01110;
   localparam logic [4:0] c_OP_DIV    = 5'b01111;
   localparam logic [4:0] c_OP_DIVU   = 5'b10000;
   localparam logic [4:0] c_OP_REM    = 5'b10001;
   localparam logic [4:0] c_OP_REMU   = 5'b10010;
   localparam logic [XLEN-1:0] c_MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [5:0]      c_LAST_CNT = 6'(XLEN-1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [4:0]          r_op;
   logic [2*XLEN-1:0]   r_acc;
   logic [XLEN-1:0]     r_opnd;
   logic [5:0]          r_cnt;
   logic                r_sgn_a;
   logic                r_sgn_b;
   logic [XLEN-1:0]     r_result;

   // Request decode and operand conditioning
   logic            w_valid, w_is_div_in, w_rem_in, w_sgn_a_in, w_sgn_b_in;
   logic            w_div0, w_ovf;
   logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_res;

   assign w_valid     = (ALU_Ctrl >= c_OP_MUL) && (ALU_Ctrl <= c_OP_REMU);
   assign w_is_div_in = (ALU_Ctrl >= c_OP_DIV);
   assign w_rem_in    = (ALU_Ctrl == c_OP_REM) || (ALU_Ctrl == c_OP_REMU);
   assign w_sgn_a_in  = op_a[XLEN-1] && ((ALU_Ctrl == c_OP_MULH) || (ALU_Ctrl == c_OP_MULHSU) ||
                                         (ALU_Ctrl == c_OP_DIV)  || (ALU_Ctrl == c_OP_REM));
   assign w_sgn_b_in  = op_b[XLEN-1] && ((ALU_Ctrl == c_OP_MULH) ||
                                         (ALU_Ctrl == c_OP_DIV)  || (ALU_Ctrl == c_OP_REM));
   assign w_mag_a     = w_sgn_a_in ? -op_a : op_a;
   assign w_mag_b     = w_sgn_b_in ? -op_b : op_b;
   assign w_div0      = w_is_div_in && (op_b == '0);
   assign w_ovf       = ((ALU_Ctrl == c_OP_DIV) || (ALU_Ctrl == c_OP_REM)) &&
                        (op_a == c_MIN_INT) && (op_b == '1);
   assign w_special_res = w_div0 ? (w_rem_in ? op_a : '1) : (w_rem_in ? '0 : c_MIN_INT);

   logic            w_fast_take;
   logic [XLEN-1:0] w_fast_res;
`ifdef MULDIV_FAST_MUL_EN
   logic signed [2*XLEN-1:0] w_fa, w_fb, w_fp;
   assign w_fa        = {{XLEN{w_sgn_a_in}}, op_a};
   assign w_fb        = {{XLEN{w_sgn_b_in}}, op_b};
   assign w_fp        = w_fa * w_fb;
   assign w_fast_take = w_valid && !w_is_div_in;
   assign w_fast_res  = (ALU_Ctrl == c_OP_MUL) ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN];
`else
   assign w_fast_take = 1'b0;
   assign w_fast_res  = '0;
`endif

   // One radix-2 step: multiply adds into the upper half then shifts right,
   // divide shifts left and keeps the trial difference when it does not borrow.
   logic              w_is_div;
   logic [XLEN:0]     w_add, w_rem_sh, w_diff;
   logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_acc_nxt, w_prod;
   logic [XLEN-1:0]   w_quot, w_remd, w_calc_res;

   assign w_is_div  = (r_op >= c_OP_DIV);
   assign w_add     = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
   assign w_mul_nxt = r_acc[0] ? {w_add, r_acc[XLEN-1:1]}
                               : {1'b0, r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1:1]};
   assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
   assign w_diff    = w_rem_sh - {1'b0, r_opnd};
   assign w_div_nxt = w_diff[XLEN] ? {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1};
   assign w_acc_nxt = w_is_div ? w_div_nxt : w_mul_nxt;

   assign w_prod = (r_sgn_a ^ r_sgn_b) ? -w_acc_nxt : w_acc_nxt;
   assign w_quot = (r_sgn_a ^ r_sgn_b) ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
   assign w_remd = r_sgn_a ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];

   always_comb begin
      w_calc_res = w_remd;
      case (r_op)
         c_OP_MUL:                           w_calc_res = w_prod[XLEN-1:0];
         c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: w_calc_res = w_prod[2*XLEN-1:XLEN];
         c_OP_DIV, c_OP_DIVU:                w_calc_res = w_quot;
         default:                            w_calc_res = w_remd;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_op     <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_cnt    <= '0;
         r_sgn_a  <= 1'b0;
         r_sgn_b  <= 1'b0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && w_valid) begin
                  r_op    <= ALU_Ctrl;
                  r_sgn_a <= w_sgn_a_in;
                  r_sgn_b <= w_sgn_b_in;
                  r_cnt   <= '0;
                  if (w_div0 || w_ovf) begin
                     r_result <= w_special_res;
                     r_state  <= S_DONE;
                  end else if (w_fast_take) begin
                     r_result <= w_fast_res;
                     r_state  <= S_DONE;
                  end else begin
                     r_opnd  <= w_is_div_in ? w_mag_b : w_mag_a;
                     r_acc   <= {{XLEN{1'b0}}, (w_is_div_in ? w_mag_a : w_mag_b)};
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_acc <= w_acc_nxt;
               if (r_cnt == c_LAST_CNT) begin
                  r_result <= w_calc_res;
                  r_cnt    <= '0;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);
   assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Scoreboard bench for muldiv_unit: directed and random RV32M ops
//            against an arithmetic reference model (honours MULDIV_FAST_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

   localparam logic [4:0] c_MUL    = 5'b01011;
   localparam logic [4:0] c_MULH   = 5'b01100;
   localparam logic [4:0] c_MULHSU = 5'b01101;
   localparam logic [4:0] c_MULHU  = 5'b01110;
   localparam logic [4:0] c_DIV    = 5'b01111;
   localparam logic [4:0] c_DIVU   = 5'b10000;
   localparam logic [4:0] c_REM    = 5'b10001;
   localparam logic [4:0] c_REMU   = 5'b10010;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [4:0]  ALU_Ctrl = '0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic        busy, done;
   logic [31:0] result;

   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   int          cyc_q[$];

   muldiv_unit #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ALU_Ctrl(ALU_Ctrl),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa = longint'($signed(a));
      longint      sb = longint'($signed(b));
      longint      ua = longint'({32'b0, a});
      longint      ub = longint'({32'b0, b});
      logic [63:0] p;
      p = '0;
      case (op)
         c_MUL:    begin p = ua * ub; return p[31:0];  end
         c_MULH:   begin p = sa * sb; return p[63:32]; end
         c_MULHSU: begin p = sa * ub; return p[63:32]; end
         c_MULHU:  begin p = ua * ub; return p[63:32]; end
         c_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         c_DIVU: begin
            if (b == 0) return 32'hFFFF_FFFF;
            p = ua / ub; return p[31:0];
         end
         c_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: begin
            if (b == 0) return a;
            p = ua % ub; return p[31:0];
         end
      endcase
   endfunction

   // Cycles from the start cycle to the done cycle
   function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op >= c_DIV && b == 0) return 1;
      if ((op == c_DIV || op == c_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (op < c_DIV) return 1;
`endif
      return 33;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Called just after a negedge; leaves start low after one cycle
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; ALU_Ctrl = op; op_a = a; op_b = b;
      if (op >= c_MUL && op <= c_REMU) begin
         exp_q.push_back(ref_model(op, a, b));
         cyc_q.push_back(cyc + ref_lat(op, a, b));
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 60) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n >= 60) begin
         n_fail++;
         $display("FAIL wait_idle: timed out after %0d cycles, busy=%b pending=%0d", n, busy, exp_q.size());
         exp_q.delete();
         cyc_q.delete();
      end
   endtask

   task automatic run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      issue(op, a, b);
      wait_idle();
   endtask

   // Monitor: pops the scoreboard whenever done is presented
   logic prev_done = 1'b0;
   always @(negedge clk) begin : mon
      logic [31:0] er;
      int          ec;
      if (done) begin
         n_checks++;
         if (prev_done) begin
            n_fail++;
            $display("FAIL done_pulse: done high for two consecutive cycles at cycle %0d", cyc);
         end
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: done=1 with nothing pending at cycle %0d, result %h", cyc, result);
         end else begin
            er = exp_q.pop_front();
            ec = cyc_q.pop_front();
            check("result", result, er);
            n_checks++;
            if (cyc != ec) begin
               n_fail++;
               $display("FAIL latency: done at cycle %0d, expected cycle %0d", cyc, ec);
            end
         end
      end
      prev_done = done;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [4:0]  op;
      logic [31:0] a, b;
      repeat (3) @(negedge clk);
      check("reset_busy",   {31'b0, busy}, 32'd0);
      check("reset_done",   {31'b0, done}, 32'd0);
      check("reset_result", result,        32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run(c_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(c_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(c_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run(c_DIV,   32'hFFFF_FFF9, 32'd2);
      run(c_REM,   32'hFFFF_FFF9, 32'd2);
      run(c_DIVU,  32'd100, 32'd7);
      run(c_REMU,  32'd100, 32'd7);
      run(c_DIVU,  32'd5, 32'd0);
      run(c_REMU,  32'd5, 32'd0);
      run(c_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      run(c_REM,   32'h8000_0000, 32'hFFFF_FFFF);
      check("result_hold", result, 32'd0);

      // Start pulse while busy must be ignored
      issue(c_DIVU, 32'd1000, 32'd3);
      repeat (8) @(negedge clk);
      start = 1'b1; ALU_Ctrl = c_DIVU; op_a = 32'd50; op_b = 32'd5;
      @(negedge clk);
      start = 1'b0;
      check("busy_during_ignored_start", {31'b0, busy}, 32'd1);
      wait_idle();
      repeat (3) @(negedge clk);

      // Unsupported code: no busy, no done
      start = 1'b1; ALU_Ctrl = 5'b00000; op_a = 32'd9; op_b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      check("illegal_busy", {31'b0, busy}, 32'd0);
      repeat (3) @(negedge clk);
      check("illegal_done", {31'b0, done}, 32'd0);

      // Reset in the middle of a divide
      issue(c_DIV, 32'hFFFF_FFF9, 32'd2);
      repeat (13) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset_busy",   {31'b0, busy}, 32'd0);
      check("midreset_done",   {31'b0, done}, 32'd0);
      check("midreset_result", result,        32'd0);
      exp_q.delete();
      cyc_q.delete();
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      run(c_MUL, 32'd3, 32'd4);

      // Randomised operations with a bias toward corner operands
      for (int i = 0; i < 80; i++) begin
         op = 5'(c_MUL + 5'($urandom_range(0, 7)));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'h8000_0000;
            4: b = 32'hFFFF_FFFF;
            default: ;
         endcase
         run(op, a, b);
      end

      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
